// File: rtl/reg_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_pkg
// Description : Shared encodings for the writeback stage. The instruction
//               decoder produces wb_sel / load_type using these same codes,
//               so both sides stay consistent.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_wb_pkg;

    localparam int c_XLEN       = 32;
    localparam int c_REG_ADDR_W = 5;

    // Writeback source select
    localparam logic [1:0] c_WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] c_WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] c_WB_SEL_LINK = 2'b10;
    localparam logic [1:0] c_WB_SEL_RSVD = 2'b11;

    // Load width / extension type
    localparam logic [2:0] c_LD_LW  = 3'b000;
    localparam logic [2:0] c_LD_LH  = 3'b001;
    localparam logic [2:0] c_LD_LHU = 3'b010;
    localparam logic [2:0] c_LD_LB  = 3'b011;
    localparam logic [2:0] c_LD_LBU = 3'b100;

    // The reserved source code never produces a register write.
    function automatic logic wb_sel_writes(input logic [1:0] sel);
        return (sel != c_WB_SEL_RSVD);
    endfunction

endpackage : reg_wb_pkg
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Combinational little-endian load lane extraction with sign /
//               zero extension to 32 bits.
// Ports       : i_load_data  - aligned 32-bit word from data memory
//               i_addr_lo    - byte address bits [1:0]
//               i_load_type  - LW/LH/LHU/LB/LBU code
//               o_value      - extended load result (0 for unused codes)
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import reg_wb_pkg::*;
(
    input  logic [c_XLEN-1:0] i_load_data,
    input  logic [1:0]        i_addr_lo,
    input  logic [2:0]        i_load_type,
    output logic [c_XLEN-1:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'b00:   w_byte = i_load_data[7:0];
            2'b01:   w_byte = i_load_data[15:8];
            2'b10:   w_byte = i_load_data[23:16];
            default: w_byte = i_load_data[31:24];
        endcase
    end

    // Halfword lane uses address bit 1 only; bit 0 is deliberately ignored.
    assign w_half = i_addr_lo[1] ? i_load_data[31:16] : i_load_data[15:0];

    always_comb begin
        o_value = '0;
        case (i_load_type)
            c_LD_LW:  o_value = i_load_data;
            c_LD_LH:  o_value = {{16{w_half[15]}}, w_half};
            c_LD_LHU: o_value = {16'h0000, w_half};
            c_LD_LB:  o_value = {{24{w_byte[7]}}, w_byte};
            c_LD_LBU: o_value = {24'h000000, w_byte};
            default:  o_value = '0;
        endcase
    end

endmodule : load_extract
`default_nettype wire

// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module      : reg_writeback
// Description : MEM/WB pipeline register plus writeback data selection,
//               register-file write port, forwarding port and a retired-
//               instruction counter.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               mem_*                - instruction arriving from MEM stage
//               wb_stall / wb_flush  - hold / kill control for WB register
//               REG_*                - register-file write port
//               fwd_*                - forwarding copy of the write port
//               retire_count         - instructions that have left WB
// Revision    : 1.0 - initial release
// ============================================================================
module reg_writeback
    import reg_wb_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    input  logic                    mem_reg_write,
    input  logic [c_REG_ADDR_W-1:0] mem_rd_addr,
    input  logic [1:0]              mem_wb_sel,
    input  logic [c_XLEN-1:0]       mem_alu_result,
    input  logic [c_XLEN-1:0]       mem_load_data,
    input  logic [2:0]              mem_load_type,
    input  logic [c_XLEN-1:0]       mem_pc_plus4,
    input  logic                    wb_stall,
    input  logic                    wb_flush,
    output logic                    REG_write_1,
    output logic [c_REG_ADDR_W-1:0] REG_address_wr,
    output logic [c_XLEN-1:0]       REG_data_wb_in1,
    output logic                    fwd_valid,
    output logic [c_REG_ADDR_W-1:0] fwd_addr,
    output logic [c_XLEN-1:0]       fwd_data,
    output logic [RETIRE_W-1:0]     retire_count
);

    logic                    r_valid;
    logic                    r_reg_write;
    logic [c_REG_ADDR_W-1:0] r_rd;
    logic [1:0]              r_wb_sel;
    logic [2:0]              r_load_type;
    logic [c_XLEN-1:0]       r_alu_result;
    logic [c_XLEN-1:0]       r_load_data;
    logic [c_XLEN-1:0]       r_pc_plus4;
    logic [RETIRE_W-1:0]     r_retire_count;

    logic [c_XLEN-1:0]       w_load_value;
    logic [c_XLEN-1:0]       w_sel_data;
    logic                    w_write;

    // Pipeline register. An instruction leaves WB on any edge where it is
    // valid and not stalled; a simultaneous flush only kills the incoming one,
    // so the outgoing instruction is still counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid        <= 1'b0;
            r_reg_write    <= 1'b0;
            r_rd           <= '0;
            r_wb_sel       <= '0;
            r_load_type    <= '0;
            r_alu_result   <= '0;
            r_load_data    <= '0;
            r_pc_plus4     <= '0;
            r_retire_count <= '0;
        end else begin
            if (r_valid && !wb_stall) begin
                r_retire_count <= r_retire_count + RETIRE_W'(1);
            end
            if (wb_flush) begin
                r_valid <= 1'b0;
            end else if (!wb_stall) begin
                r_valid      <= mem_valid;
                r_reg_write  <= mem_reg_write;
                r_rd         <= mem_rd_addr;
                r_wb_sel     <= mem_wb_sel;
                r_load_type  <= mem_load_type;
                r_alu_result <= mem_alu_result;
                r_load_data  <= mem_load_data;
                r_pc_plus4   <= mem_pc_plus4;
            end
        end
    end

    load_extract u_load_extract (
        .i_load_data (r_load_data),
        .i_addr_lo   (r_alu_result[1:0]),
        .i_load_type (r_load_type),
        .o_value     (w_load_value)
    );

    always_comb begin
        w_sel_data = '0;
        case (r_wb_sel)
            c_WB_SEL_ALU:  w_sel_data = r_alu_result;
            c_WB_SEL_LOAD: w_sel_data = w_load_value;
            c_WB_SEL_LINK: w_sel_data = r_pc_plus4;
            default:       w_sel_data = '0;
        endcase
    end

    // x0 is hard-wired zero, so writes to it are suppressed here rather than
    // relying on the register file to ignore them; forwarding sees the same.
    assign w_write = r_valid && r_reg_write && (r_rd != '0) && wb_sel_writes(r_wb_sel);

    assign REG_write_1     = w_write;
    assign REG_address_wr  = r_valid ? r_rd : '0;
    assign REG_data_wb_in1 = r_valid ? w_sel_data : '0;

    assign fwd_valid = REG_write_1;
    assign fwd_addr  = REG_address_wr;
    assign fwd_data  = REG_data_wb_in1;

    assign retire_count = r_retire_count;

endmodule : reg_writeback
`default_nettype wire

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL expose parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 The block SHALL expose the following ports, one per line (name, direction, width, meaning):
  clk  input  1  sole clock, all state on rising edge
  rst  input  1  reset, synchronous, active-high
  mem_valid  input  1  MEM stage holds a valid instruction
  mem_reg_write  input  1  instruction writes a register
  mem_rd_addr  input  5  destination register
  mem_wb_sel  input  2  writeback source: 00 ALU, 01 load, 10 link, 11 reserved
  mem_alu_result  input  32  ALU result, also load byte address
  mem_load_data  input  32  aligned word read from data memory
  mem_load_type  input  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU
  mem_pc_plus4  input  32  link value for JAL/JALR
  wb_stall  input  1  hold WB register contents
  wb_flush  input  1  kill instruction entering WB
  REG_write_1  output  1  register-file write enable
  REG_address_wr  output  5  register-file write address
  REG_data_wb_in1  output  32  register-file write data
  fwd_valid  output  1  forwarding value present
  fwd_addr  output  5  forwarding destination
  fwd_data  output  32  forwarding value
  retire_count  output  RETIRE_W  instructions retired

Function
REQ-003 The block SHALL hold a single MEM/WB pipeline register (valid, reg_write, rd, wb_sel, load_type, alu_result, load_data, pc_plus4) updated on the rising edge of clk.
REQ-004 The block SHALL load the register from mem_* when wb_stall=0 and wb_flush=0, giving one cycle latency from MEM inputs to REG_* outputs.
REQ-005 The block SHALL hold all register contents unchanged when wb_stall=1 and wb_flush=0.
REQ-006 The block SHALL clear the valid bit when wb_flush=1, with flush taking priority over stall; other fields are don't-care.
REQ-007 The block SHALL select writeback data combinationally from the register: 00 alu_result, 01 extracted load value, 10 pc_plus4, 11 zero.
REQ-008 The block SHALL extract loads little-endian: byte lane = alu_result[1:0], halfword lane = alu_result[1]; alu_result[0] ignored for halfwords; LW ignores alu_result[1:0].
REQ-009 The block SHALL sign-extend LB/LH and zero-extend LBU/LHU to 32 bits; unused load_type codes SHALL yield zero.
REQ-010 The block SHALL assert REG_write_1 only when valid=1, reg_write=1, rd!=0 and wb_sel!=11.
REQ-011 REG_address_wr and REG_data_wb_in1 SHALL present the registered rd and selected data whenever valid=1, and zero when valid=0.
REQ-012 fwd_valid, fwd_addr and fwd_data SHALL equal REG_write_1, REG_address_wr and REG_data_wb_in1 in the same cycle.
REQ-013 During a stall the held write SHALL be re-presented every cycle (idempotent rewrite of the same value).
REQ-014 retire_count SHALL increment by 1 on each rising edge where valid=1 and wb_stall=0 (instruction leaves WB), including non-writing instructions, and SHALL wrap from 2^RETIRE_W-1 to 0.
REQ-015 When wb_flush=1 and wb_stall=0 in the same cycle with valid=1, the outgoing instruction SHALL still be counted as retired.

Reset
REQ-016 When rst=1 at a rising edge, valid, all pipeline fields and retire_count SHALL become zero, overriding stall and flush.
REQ-017 While reset state holds, REG_write_1=0, REG_address_wr=0, REG_data_wb_in1=0, fwd_valid=0, fwd_addr=0, fwd_data=0, retire_count=0.
REQ-018 An instruction in WB when rst is asserted mid-operation SHALL be discarded and not counted.

Structure
REQ-019 Constants for wb_sel codes and load_type codes SHALL reside in shared package reg_wb_pkg, also used by the decoder.
REQ-020 Load extraction (REQ-008/009) SHALL be a combinational sub-module named load_extract.

Verification
REQ-021 ALU write: rd=5, wb_sel=00, alu_result=0x12345678 -> next cycle REG_write_1=1, REG_address_wr=5, REG_data_wb_in1=0x12345678, retire_count+1.
REQ-022 Loads: load_data=0x80FF7F01, addr low bits=11 LB -> 0xFFFFFF80; addr 10 LHU -> 0x000080FF; addr 01 LBU -> 0x0000007F; addr 10 LH -> 0xFFFF80FF.
REQ-023 Zero register: rd=0, reg_write=1 -> REG_write_1=0, fwd_valid=0, retire_count still increments.
REQ-024 Stall then flush: load JAL (pc_plus4=0x00400008, rd=31), stall 3 cycles -> REG_write_1=1 held each cycle, count unchanged; assert flush+stall -> valid drops, count unchanged.
REQ-025 Reset mid-operation: valid write in WB, rst=1 -> next cycle all outputs zero, retire_count=0.
REQ-026 Counter wrap with RETIRE_W=4: 16 consecutive valid non-stalled instructions -> retire_count returns to 0.
